clk_div_ctrl: RTL and testbench
===============================

// Module: clk_div_ctrl
// PURPOSE
//  Sequences the clock-divider / gate-enable datapath: owns division count dcnt and per-period gate_en.
//  Accepts ratio/enable configs over a valid/ready handshake; applies them only at a period boundary
//  so gate_en never produces a runt period. Sits between the config register block and the gate cells.
// PARAMETERS
//  CNT_W    8   width of dcnt
//  NUM_W    4   width of dnum ratio field
//  MAX_DIV  8   largest legal ratio; larger values select bypass
// PORTS
//  clk        in   1      sole clock
//  rst        in   1      synchronous, active-high reset
//  div_en     in   1      run enable; low freezes counter
//  cfg_valid  in   1      config request
//  cfg_ready  out  1      config accept; transfer = cfg_valid & cfg_ready
//  cfg_den    in   1      0 = bypass (gate_en held 1)
//  cfg_dnum   in   NUM_W  ratio N, legal 1..MAX_DIV
//  dcnt       out  CNT_W  current phase, 0..N-1
//  gate_en    out  1      1 in the cycle dcnt==0 (RUN), constant 1 (BYPASS)
//  busy       out  1      1 while a config is pending (PEND)
//  cfg_err    out  1      one-cycle pulse: accepted config had den=1 with dnum==0 or >MAX_DIV
// BEHAVIOUR
//  - All outputs registered. Reset: state=BYPASS, active N=0, den=0, dcnt=0, gate_en=0, busy=0, cfg_err=0,
//    shadow config cleared. Reset mid-PEND discards shadow. First cycle after reset release: gate_en=1.
//  - States: BYPASS, RUN, PEND. cfg_ready = (state != PEND).
//  - BYPASS: gate_en=1, dcnt=0. An accepted legal config (den=1, 1<=dnum<=MAX_DIV) goes to RUN next cycle
//    with dcnt=0 and gate_en=div_en. Illegal/den=0 config stays in BYPASS; cfg_err pulses if den=1.
//  - RUN, div_en=1: dcnt_nxt = (dcnt==N-1) ? 0 : dcnt+1; gate_en_nxt = (dcnt_nxt==0).
//    N=1: dcnt stays 0, gate_en=1 every cycle.
//  - RUN, div_en=0: dcnt holds, gate_en=0; on div_en=1 the count resumes from the held value.
//  - Config accepted in RUN -> PEND (busy=1), latched in shadow. This holds even when acceptance coincides
//    with dcnt==N-1: the config applies at the NEXT boundary, never the current one.
//  - PEND: counting continues with the old N. When div_en=1 and dcnt==N-1, the shadow applies on the
//    following cycle: dcnt=0, gate_en=1, state=RUN (legal) or BYPASS (den=0/illegal).
//    If div_en=0 in any PEND cycle, the shadow applies next cycle regardless of phase (no deadlock).
//  - cfg_err pulses in the cycle after acceptance; an illegal config still takes effect (as bypass).
//  - Width rule: N compared at CNT_W bits (zero-extended); dcnt never exceeds MAX_DIV-1.
// CONFIGURATION
//  CLK_DIV_CTRL_PERIOD_CNT_EN defined: extra output period_cnt[15:0].
//    - Increments on each RUN wrap (dcnt N-1 -> 0); saturates at 16'hFFFF.
//    - Cleared on reset and whenever a config is applied.
//  Undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  clk_div_pkg: state enum {BYPASS,RUN,PEND}, MAX_DIV default, CNT_W/NUM_W defaults, cfg struct {den,dnum}.
//  Sub-module clk_div_counter: phase counter with hold, sync clear, and wrap flag. The FSM and handshake
//  live in clk_div_ctrl.
// TESTING
//  1 Reset, no cfg -> from first post-reset cycle, gate_en=1 and dcnt=0 for 20 cycles; cfg_ready=1.
//  2 cfg den=1,dnum=4, div_en=1 -> dcnt 0,1,2,3,0...; gate_en high 1 of 4 cycles.
//  3 RUN N=4, cfg dnum=2 accepted at dcnt=1 -> busy=1, cfg_ready=0; old sequence 2,3 completes,
//    then 0,1,0,1; no gate_en gap or double pulse.
//  4 RUN N=3, cfg accepted at dcnt=2 -> new N applies only after one full further period (0,1,2).
//  5 cfg den=1,dnum=9 -> cfg_err single pulse, BYPASS, gate_en=1; repeat with dnum=0 -> same result.
//  6 PEND with div_en dropped -> shadow applies next cycle; then rst asserted mid-PEND -> all reset values,
//    shadow discarded; with CLK_DIV_CTRL_PERIOD_CNT_EN, N=2 for 10 wraps gives period_cnt=10.

Source files
------------

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and defaults for the clock-divider control slice.
//   state_t : controller state (BYPASS / RUN / PEND)
//   cfg_t   : configuration word {den, dnum} at the default ratio width
//   *_DFLT  : default widths and the largest legal division ratio
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int CNT_W_DFLT   = 8;
  localparam int NUM_W_DFLT   = 4;
  localparam int MAX_DIV_DFLT = 8;

  typedef enum logic [1:0] {
    ST_BYPASS = 2'd0,
    ST_RUN    = 2'd1,
    ST_PEND   = 2'd2
  } state_t;

  typedef struct packed {
    logic                  den;
    logic [NUM_W_DFLT-1:0] dnum;
  } cfg_t;

endpackage : clk_div_pkg

// File: rtl/clk_div_counter.sv
// -----------------------------------------------------------------------------
// clk_div_counter
// Phase counter for the divider: counts 0..N-1 while advancing, holds when not
// advancing, and clears synchronously on request (clear wins over advance).
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (count -> 0)
//   adv_i   : advance the phase this cycle
//   clr_i   : force the phase to 0 next cycle
//   n_i     : active ratio N (zero-extended to CNT_W)
//   cnt_o   : current phase
//   wrap_o  : phase is N-1 and advancing, i.e. next phase is 0 by wrap
// -----------------------------------------------------------------------------
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] n_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last;

  // With N=1 this is always true, so the phase sits at 0 and wraps every cycle.
  assign last = (cnt_q == (n_i - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = last ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = adv_i & last;

endmodule : clk_div_counter

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Sequences the clock-divider / gate-enable datapath. Owns the division phase
// (dcnt) and the per-period gate enable. Ratio/enable configs arrive over a
// valid/ready handshake and are only applied at a period boundary so gate_en
// never produces a runt period.
//
// Optional feature (macro CLK_DIV_CTRL_PERIOD_CNT_EN):
//   adds output period_cnt[15:0], a saturating count of RUN wraps, cleared on
//   reset and whenever a config is applied.
//
// Ports:
//   clk        : sole clock
//   rst        : synchronous active-high reset
//   div_en     : run enable; low freezes the phase
//   cfg_valid  : config request
//   cfg_ready  : config accept (low only while a config is pending)
//   cfg_den    : 0 = bypass (gate_en held 1)
//   cfg_dnum   : ratio N, legal 1..MAX_DIV
//   dcnt       : current phase 0..N-1
//   gate_en    : 1 in the phase-0 cycle (RUN), constant 1 (BYPASS)
//   busy       : 1 while a config is pending
//   cfg_err    : one-cycle pulse after accepting den=1 with an illegal ratio
//   period_cnt : (optional) saturating RUN wrap count
// -----------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DFLT,
  parameter int NUM_W   = NUM_W_DFLT,
  parameter int MAX_DIV = MAX_DIV_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_den,
  input  logic [NUM_W-1:0] cfg_dnum,
  output logic [CNT_W-1:0] dcnt,
  output logic             gate_en,
  output logic             busy,
  output logic             cfg_err
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  // Ratio is compared at counter width so oversize dnum values are caught.
  function automatic logic cfg_is_legal(input logic den, input logic [NUM_W-1:0] dnum);
    logic [CNT_W-1:0] n_ext;
    n_ext = CNT_W'(dnum);
    return den && (n_ext != '0) && (n_ext <= CNT_W'(MAX_DIV));
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] n_q;
  logic             gate_en_q;
  logic             busy_q;
  logic             cfg_err_q;
  logic             sh_den_q;
  logic [NUM_W-1:0] sh_dnum_q;

  logic             xfer;
  logic             in_legal;
  logic             sh_legal;
  logic             pend_apply;
  logic             cnt_adv;
  logic             cnt_clr;
  logic             wrap;
  logic [CNT_W-1:0] cnt;

  assign cfg_ready = (state_q != ST_PEND);
  assign xfer      = cfg_valid & cfg_ready;
  assign in_legal  = cfg_is_legal(cfg_den, cfg_dnum);
  assign sh_legal  = cfg_is_legal(sh_den_q, sh_dnum_q);

  // A pending config lands at the next wrap; if the run enable is dropped the
  // wrap may never come, so it lands immediately instead.
  assign pend_apply = (state_q == ST_PEND) && (!div_en || wrap);

  assign cnt_adv = div_en && ((state_q == ST_RUN) || (state_q == ST_PEND));
  assign cnt_clr = (state_q == ST_BYPASS) || pend_apply;

  clk_div_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i  (clk),
    .rst_i  (rst),
    .adv_i  (cnt_adv),
    .clr_i  (cnt_clr),
    .n_i    (n_q),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BYPASS;
      n_q       <= '0;
      gate_en_q <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      sh_den_q  <= 1'b0;
      sh_dnum_q <= '0;
    end else begin
      // Error pulse follows acceptance, whichever state accepted it.
      cfg_err_q <= xfer & cfg_den & ~in_legal;

      case (state_q)
        ST_BYPASS: begin
          gate_en_q <= 1'b1;
          busy_q    <= 1'b0;
          if (xfer && in_legal) begin
            state_q   <= ST_RUN;
            n_q       <= CNT_W'(cfg_dnum);
            gate_en_q <= div_en;
          end
        end

        ST_RUN: begin
          gate_en_q <= wrap;
          // Even when accepted on the last phase, the shadow waits for the
          // following boundary: PEND always sees one full old-ratio period.
          if (xfer) begin
            state_q   <= ST_PEND;
            busy_q    <= 1'b1;
            sh_den_q  <= cfg_den;
            sh_dnum_q <= cfg_dnum;
          end
        end

        ST_PEND: begin
          if (pend_apply) begin
            gate_en_q <= 1'b1;
            busy_q    <= 1'b0;
            if (sh_legal) begin
              state_q <= ST_RUN;
              n_q     <= CNT_W'(sh_dnum_q);
            end else begin
              state_q <= ST_BYPASS;
              n_q     <= '0;
            end
          end else begin
            gate_en_q <= wrap;
          end
        end

        default: begin
          state_q   <= ST_BYPASS;
          n_q       <= '0;
          gate_en_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dcnt    = cnt;
  assign gate_en = gate_en_q;
  assign busy    = busy_q;
  assign cfg_err = cfg_err_q;

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic        cfg_applied;
  logic [15:0] period_cnt_q;

  assign cfg_applied = ((state_q == ST_BYPASS) && xfer) || pend_apply;

  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt_q <= '0;
    end else if (cfg_applied) begin
      period_cnt_q <= '0;
    end else if ((state_q == ST_RUN) && wrap && (period_cnt_q != 16'hFFFF)) begin
      period_cnt_q <= period_cnt_q + 16'd1;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule : clk_div_ctrl

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Directed testbench for clk_div_ctrl with hand-computed expected values.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at the same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst;
  logic       div_en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_den;
  logic [3:0] cfg_dnum;
  logic [7:0] dcnt;
  logic       gate_en;
  logic       busy;
  logic       cfg_err;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  int n_checks;
  int n_errors;

  clk_div_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .div_en    (div_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_den   (cfg_den),
    .cfg_dnum  (cfg_dnum),
    .dcnt      (dcnt),
    .gate_en   (gate_en),
    .busy      (busy),
    .cfg_err   (cfg_err)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cfg_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic send_cfg(input logic den, input logic [3:0] n);
    cfg_valid = 1'b1;
    cfg_den   = den;
    cfg_dnum  = n;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int exp_dcnt, input logic exp_gate, input logic exp_busy);
    check_eq({tag, ".dcnt"}, 32'(dcnt), 32'(exp_dcnt));
    check_eq({tag, ".gate"}, 32'(gate_en), 32'(exp_gate));
    check_eq({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  // Expected (dcnt, gate, busy) after each cycle following a mid-period reconfig.
  int t3_dcnt [6] = '{3, 0, 1, 0, 1, 0};
  int t3_gate [6] = '{0, 1, 0, 1, 0, 1};
  int t3_busy [6] = '{1, 0, 0, 0, 0, 0};
  int t4_dcnt [6] = '{0, 1, 2, 0, 1, 0};
  int t4_gate [6] = '{1, 0, 0, 1, 0, 1};
  int t4_busy [6] = '{1, 1, 1, 0, 0, 0};

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    div_en    = 1'b0;
    cfg_valid = 1'b0;
    cfg_den   = 1'b0;
    cfg_dnum  = 4'd0;

    // ---- reset values and idle bypass
    step();
    step();
    check_eq("rst.gate", 32'(gate_en), 32'd0);
    check_eq("rst.dcnt", 32'(dcnt), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.err", 32'(cfg_err), 32'd0);
    check_eq("rst.ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("byp.gate", 32'(gate_en), 32'd1);
      check_eq("byp.dcnt", 32'(dcnt), 32'd0);
      check_eq("byp.ready", 32'(cfg_ready), 32'd1);
    end

    // ---- N=4 counting
    div_en = 1'b1;
    send_cfg(1'b1, 4'd4);
    expect_out("n4.entry", 0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step();
      expect_out("n4.run", k % 4, (k % 4) == 0, 1'b0);
    end

    // ---- N=4 -> N=2 accepted at dcnt=1
    step();
    check_eq("t3.pre_dcnt", 32'(dcnt), 32'd1);
    send_cfg(1'b1, 4'd2);
    expect_out("t3.acc", 2, 1'b0, 1'b1);
    check_eq("t3.ready", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      expect_out("t3.seq", t3_dcnt[i], t3_gate[i][0], t3_busy[i][0]);
    end
    check_eq("t3.ready_back", 32'(cfg_ready), 32'd1);

    // ---- N=3, config accepted on the last phase waits a full period
    do_reset();
    div_en = 1'b1;
    send_cfg(1'b1, 4'd3);
    step();
    step();
    check_eq("t4.pre_dcnt", 32'(dcnt), 32'd2);
    send_cfg(1'b1, 4'd2);
    expect_out("t4.acc", t4_dcnt[0], t4_gate[0][0], t4_busy[0][0]);
    for (int i = 1; i < 6; i++) begin
      step();
      expect_out("t4.seq", t4_dcnt[i], t4_gate[i][0], t4_busy[i][0]);
    end

    // ---- div_en low holds the phase, resumes from the held value
    do_reset();
    div_en = 1'b1;
    send_cfg(1'b1, 4'd4);
    step();
    step();
    div_en = 1'b0;
    step();
    expect_out("hold.a", 2, 1'b0, 1'b0);
    step();
    expect_out("hold.b", 2, 1'b0, 1'b0);
    div_en = 1'b1;
    step();
    expect_out("hold.c", 3, 1'b0, 1'b0);
    step();
    expect_out("hold.d", 0, 1'b1, 1'b0);

    // ---- N=1: gate every cycle
    do_reset();
    send_cfg(1'b1, 4'd1);
    expect_out("n1.entry", 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("n1.run", 0, 1'b1, 1'b0);
    end

    // ---- entering RUN with div_en low gives gate_en=0
    do_reset();
    div_en = 1'b0;
    send_cfg(1'b1, 4'd4);
    expect_out("den0.entry", 0, 1'b0, 1'b0);
    step();
    expect_out("den0.hold", 0, 1'b0, 1'b0);
    div_en = 1'b1;

    // ---- illegal configs and boundary ratio
    do_reset();
    send_cfg(1'b1, 4'd9);
    check_eq("ill9.err", 32'(cfg_err), 32'd1);
    expect_out("ill9", 0, 1'b1, 1'b0);
    check_eq("ill9.ready", 32'(cfg_ready), 32'd1);
    step();
    check_eq("ill9.err_end", 32'(cfg_err), 32'd0);
    check_eq("ill9.gate2", 32'(gate_en), 32'd1);
    send_cfg(1'b1, 4'd0);
    check_eq("ill0.err", 32'(cfg_err), 32'd1);
    expect_out("ill0", 0, 1'b1, 1'b0);
    step();
    check_eq("ill0.err_end", 32'(cfg_err), 32'd0);
    send_cfg(1'b0, 4'd4);
    check_eq("den0cfg.err", 32'(cfg_err), 32'd0);
    step();
    expect_out("den0cfg", 0, 1'b1, 1'b0);
    send_cfg(1'b1, 4'd8);
    expect_out("n8.entry", 0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step();
    expect_out("n8.last", 7, 1'b0, 1'b0);
    step();
    expect_out("n8.wrap", 0, 1'b1, 1'b0);

    // ---- PEND with div_en dropped, then reset mid-PEND
    do_reset();
    div_en = 1'b1;
    send_cfg(1'b1, 4'd4);
    step();
    send_cfg(1'b1, 4'd2);
    expect_out("t6.acc", 2, 1'b0, 1'b1);
    div_en = 1'b0;
    step();
    expect_out("t6.apply", 0, 1'b1, 1'b0);
    check_eq("t6.ready", 32'(cfg_ready), 32'd1);
    step();
    expect_out("t6.frozen", 0, 1'b0, 1'b0);
    div_en = 1'b1;
    step();
    expect_out("t6.run1", 1, 1'b0, 1'b0);
    step();
    expect_out("t6.run2", 0, 1'b1, 1'b0);
    send_cfg(1'b1, 4'd3);
    expect_out("t6.pend", 1, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    expect_out("t6.rst", 0, 1'b0, 1'b0);
    check_eq("t6.rst_err", 32'(cfg_err), 32'd0);
    check_eq("t6.rst_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("t6.post", 0, 1'b1, 1'b0);
    end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    // ---- period counter: N=2 for 10 wraps
    do_reset();
    div_en = 1'b1;
    send_cfg(1'b1, 4'd2);
    check_eq("pc.start", 32'(period_cnt), 32'd0);
    for (int i = 0; i < 20; i++) step();
    check_eq("pc.ten", 32'(period_cnt), 32'd10);
    send_cfg(1'b1, 4'd3);
    check_eq("pc.pend", 32'(period_cnt), 32'd10);
    step();
    check_eq("pc.clear", 32'(period_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_clk_div_ctrl
